// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the operands are split into STAGES chunks of WIDTH/STAGES bits,
// and each stage adds one chunk and passes its carry to the next, under a single global stall.
module pipe_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int CW = WIDTH / STAGES;

    logic              advance;
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_nx;

    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance || RST;

    // Stage k owns chunk k. Its register set holds the full operands (b already inverted for
    // subtract), the result chunks below k, and the carry into chunk k.
    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        logic [CW:0] csum;

        assign csum    = {1'b0, a_q[k][k*CW +: CW]} + {1'b0, b_q[k][k*CW +: CW]}
                       + {{CW{1'b0}}, c_q[k]};
        assign s_nx[k] = (s_q[k] & ~(WIDTH'({CW{1'b1}}) << (k*CW)))
                       | (WIDTH'(csum[CW-1:0]) << (k*CW));
        assign c_nx[k] = csum[CW];
    end

    always_ff @(posedge CLK) begin
        if (advance) begin
            a_q[0] <= A;
            b_q[0] <= MODE ? ~B : B;
            c_q[0] <= MODE ? 1'b1 : CIN;
            s_q[0] <= '0;
            for (int unsigned k = 1; k < STAGES; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_nx[k-1];
                c_q[k] <= c_nx[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q       <= '0;
            OUT_VALID <= 1'b0;
            SUM       <= '0;
            COUT      <= 1'b0;
            OVF       <= 1'b0;
        end else if (advance) begin
            v_q       <= (v_q << 1) | STAGES'(IN_VALID);
            OUT_VALID <= v_q[STAGES-1];
            SUM       <= s_nx[STAGES-1];
            COUT      <= c_nx[STAGES-1];
            OVF       <= (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                      && (s_nx[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: three instances (8/2, 4/1, 4/4), each checked against an arithmetic
// reference model through a per-instance scoreboard.
module tb_pipe_addsub;

    localparam int NDUT = 3;
    localparam int WS [NDUT] = '{8, 4, 4};
    localparam int SS [NDUT] = '{2, 1, 4};

    logic       clk = 1'b0;
    logic       rst       [NDUT];
    logic [7:0] a         [NDUT];
    logic [7:0] b         [NDUT];
    logic       cin       [NDUT];
    logic       mode      [NDUT];
    logic       in_valid  [NDUT];
    logic       out_ready [NDUT];
    logic       in_ready  [NDUT];
    logic       out_valid [NDUT];
    logic       cout      [NDUT];
    logic       ovf       [NDUT];
    logic [7:0] sum       [NDUT];
    logic       rand_rdy  [NDUT];
    int         pend      [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Result as {sum, cout, ovf}, computed from the operand values with plain integer arithmetic.
    function automatic logic [9:0] model(input int w, input logic [7:0] a8, input logic [7:0] b8,
                                         input logic ci, input logic md);
        longint m, av, bv, sa, sb, r, sr;
        logic co, ov;
        m  = longint'(1) << w;
        av = longint'(a8) % m;
        bv = longint'(b8) % m;
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        if (md) begin
            r  = av - bv;
            co = (av >= bv);
            sr = sa - sb;
        end else begin
            r  = av + bv + longint'(ci);
            co = (r >= m);
            sr = sa + sb + longint'(ci);
        end
        ov = (sr >= m / 2) || (sr < -(m / 2));
        r  = ((r % m) + m) % m;
        return {8'(r), co, ov};
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = WS[g];
        localparam int S = SS[g];
        logic [W-1:0] sum_w;
        logic [9:0]   expq [$];
        logic [9:0]   held;
        logic [9:0]   e;
        logic         stall;

        pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .CLK(clk), .RST(rst[g]), .A(a[g][W-1:0]), .B(b[g][W-1:0]), .CIN(cin[g]),
            .MODE(mode[g]), .IN_VALID(in_valid[g]), .IN_READY(in_ready[g]), .SUM(sum_w),
            .COUT(cout[g]), .OVF(ovf[g]), .OUT_VALID(out_valid[g]), .OUT_READY(out_ready[g])
        );
        assign sum[g] = 8'(sum_w);

        initial begin
            stall = 1'b0;
            held  = '0;
            forever begin
                @(negedge clk);
                check($sformatf("d%0d in_ready", g), 64'(in_ready[g]),
                      64'(rst[g] || !out_valid[g] || out_ready[g]));
                if (rst[g]) begin
                    expq.delete();
                    stall = 1'b0;
                end else begin
                    if (stall) begin
                        check($sformatf("d%0d hold valid", g), 64'(out_valid[g]), 64'(1'b1));
                        check($sformatf("d%0d hold data", g),
                              64'({sum[g], cout[g], ovf[g]}), 64'(held));
                    end
                    if (out_valid[g] && out_ready[g]) begin
                        if (expq.size() == 0) begin
                            check($sformatf("d%0d spurious output", g), 64'({sum[g], cout[g], ovf[g]}), 64'h3ff_dead);
                        end else begin
                            e = expq.pop_front();
                            check($sformatf("d%0d result {sum,cout,ovf}", g),
                                  64'({sum[g], cout[g], ovf[g]}), 64'(e));
                        end
                    end
                    stall = out_valid[g] && !out_ready[g];
                    held  = {sum[g], cout[g], ovf[g]};
                    if (in_valid[g] && in_ready[g])
                        expq.push_back(model(W, a[g], b[g], cin[g], mode[g]));
                end
                pend[g] = expq.size();
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        for (int g = 0; g < NDUT; g++)
            if (rand_rdy[g]) out_ready[g] = 1'($urandom_range(0, 1));
    end

    // Presents one transaction and returns 2ns after the edge that accepted it.
    task automatic send(input int g, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic md);
        a[g] = av; b[g] = bv; cin[g] = ci; mode[g] = md; in_valid[g] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready[g]) begin
                @(posedge clk);
                #2;
                in_valid[g] = 1'b0;
                return;
            end
            @(posedge clk);
            #2;
        end
        check($sformatf("d%0d accept timeout", g), 64'(1'b0), 64'(1'b1));
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_result(input int g, input string tag, input logic [7:0] es,
                               input logic ec, input logic eo);
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (out_valid[g] && out_ready[g]) begin
                seen = 1'b1;
                check({tag, " sum"}, 64'(sum[g]), 64'(es));
                check({tag, " cout"}, 64'(cout[g]), 64'(ec));
                check({tag, " ovf"}, 64'(ovf[g]), 64'(eo));
            end
        end
        if (!seen) check({tag, " result timeout"}, 64'(1'b0), 64'(1'b1));
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            rst[g] = 1'b1; a[g] = '0; b[g] = '0; cin[g] = 1'b0; mode[g] = 1'b0;
            in_valid[g] = 1'b0; out_ready[g] = 1'b1; rand_rdy[g] = 1'b0; pend[g] = 0;
        end

        // Reset state
        @(posedge clk); #2;
        @(negedge clk);
        check("reset out_valid", 64'(out_valid[0]), 64'(1'b0));
        check("reset sum", 64'(sum[0]), 64'(8'h00));
        check("reset cout", 64'(cout[0]), 64'(1'b0));
        check("reset ovf", 64'(ovf[0]), 64'(1'b0));
        check("reset in_ready", 64'(in_ready[0]), 64'(1'b1));
        @(posedge clk); #2;
        for (int g = 0; g < NDUT; g++) rst[g] = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 64'(in_ready[0]), 64'(1'b1));
        @(posedge clk); #2;

        // Latency: FF+01 presented two edges after acceptance
        send(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        check("latency +0 out_valid", 64'(out_valid[0]), 64'(1'b0));
        @(posedge clk); #2;
        @(negedge clk);
        check("latency +1 out_valid", 64'(out_valid[0]), 64'(1'b0));
        @(posedge clk); #2;
        @(negedge clk);
        check("latency +2 out_valid", 64'(out_valid[0]), 64'(1'b1));
        check("ff+01 sum", 64'(sum[0]), 64'(8'h00));
        check("ff+01 cout", 64'(cout[0]), 64'(1'b1));
        check("ff+01 ovf", 64'(ovf[0]), 64'(1'b0));
        @(posedge clk); #2;

        send(0, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_result(0, "7f+01", 8'h80, 1'b0, 1'b1);
        send(0, 8'h0F, 8'h00, 1'b1, 1'b0);
        wait_result(0, "0f+00+1", 8'h10, 1'b0, 1'b0);
        send(0, 8'h05, 8'h07, 1'b1, 1'b1);
        wait_result(0, "05-07", 8'hFE, 1'b0, 1'b0);
        send(0, 8'h80, 8'h01, 1'b0, 1'b1);
        wait_result(0, "80-01", 8'h7F, 1'b1, 1'b1);

        // Stall: drop out_ready as the first of four results appears, release 3 cycles later
        fork
            begin
                send(0, 8'h11, 8'h22, 1'b0, 1'b0);
                send(0, 8'h40, 8'h05, 1'b0, 1'b0);
                send(0, 8'hF0, 8'h20, 1'b0, 1'b0);
                send(0, 8'h80, 8'h80, 1'b0, 1'b0);
            end
            begin
                bit up = 1'b0;
                for (int t = 0; t < 20 && !up; t++) begin
                    @(posedge clk); #1;
                    up = out_valid[0];
                end
                if (!up) check("stall first result timeout", 64'(1'b0), 64'(1'b1));
                out_ready[0] = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall in_ready", 64'(in_ready[0]), 64'(1'b0));
                    check("stall first sum", 64'(sum[0]), 64'(8'h33));
                    @(posedge clk);
                end
                #1 out_ready[0] = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #2;
        check("stall drained", 64'(pend[0]), 64'(0));

        // Reset with two transactions in flight
        send(0, 8'h33, 8'h44, 1'b0, 1'b0);
        send(0, 8'h55, 8'h01, 1'b0, 1'b1);
        rst[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #2;
        rst[0] = 1'b0;
        @(negedge clk);
        check("midreset out_valid", 64'(out_valid[0]), 64'(1'b0));
        check("midreset outputs", 64'({sum[0], cout[0], ovf[0]}), 64'(10'h000));
        repeat (6) @(posedge clk);
        #2;

        // Random traffic on 8/2, exhaustive sweeps on 4/1 and 4/4, all with random out_ready
        for (int g = 0; g < NDUT; g++) rand_rdy[g] = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #2; end
                end
            end
            begin
                for (int i = 0; i < 1024; i++)
                    send(1, 8'(i & 15), 8'((i >> 4) & 15), i[8], i[9]);
            end
            begin
                for (int i = 0; i < 1024; i++)
                    send(2, 8'(i & 15), 8'((i >> 4) & 15), i[8], i[9]);
            end
        join
        for (int g = 0; g < NDUT; g++) rand_rdy[g] = 1'b0;
        @(posedge clk); #3;
        for (int g = 0; g < NDUT; g++) out_ready[g] = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        for (int g = 0; g < NDUT; g++)
            check($sformatf("d%0d drained", g), 64'(pend[g]), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
